mem_arb: RTL

//   Shares one memory port between instruction fetch (IF stage) and data access (MA stage) of the diad pipeline.

---
 rtl/mem_arb_if.sv | 46 ++++
 rtl/mem_arb.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arb_if.sv
// Bundle between mem_arb and its two requesters (IF fetch, MA data) plus the external memory.
// slave = arbiter view; master = requester/memory-model view.
interface mem_arb_if #(
   parameter int unsigned ADDR_W = 24,
   parameter int unsigned DATA_W = 24
) ();
   logic              iw_if_req;
   logic [ADDR_W-1:0] iw_if_addr;
   logic              or_if_gnt;
   logic              or_if_done;
   logic [DATA_W-1:0] or_if_rdata;
   logic              or_if_err;

   logic              iw_ma_req;
   logic              iw_ma_we;
   logic [ADDR_W-1:0] iw_ma_addr;
   logic [DATA_W-1:0] iw_ma_wdata;
   logic              or_ma_gnt;
   logic              or_ma_done;
   logic [DATA_W-1:0] or_ma_rdata;
   logic              or_ma_err;

   logic              or_mem_req;
   logic              or_mem_we;
   logic [ADDR_W-1:0] or_mem_addr;
   logic [DATA_W-1:0] or_mem_wdata;
   logic              iw_mem_ack;
   logic              iw_mem_rvalid;
   logic [DATA_W-1:0] iw_mem_rdata;

   modport slave (
      input  iw_if_req, iw_if_addr, iw_ma_req, iw_ma_we, iw_ma_addr, iw_ma_wdata,
             iw_mem_ack, iw_mem_rvalid, iw_mem_rdata,
      output or_if_gnt, or_if_done, or_if_rdata, or_if_err,
             or_ma_gnt, or_ma_done, or_ma_rdata, or_ma_err,
             or_mem_req, or_mem_we, or_mem_addr, or_mem_wdata
   );

   modport master (
      output iw_if_req, iw_if_addr, iw_ma_req, iw_ma_we, iw_ma_addr, iw_ma_wdata,
             iw_mem_ack, iw_mem_rvalid, iw_mem_rdata,
      input  or_if_gnt, or_if_done, or_if_rdata, or_if_err,
             or_ma_gnt, or_ma_done, or_ma_rdata, or_ma_err,
             or_mem_req, or_mem_we, or_mem_addr, or_mem_wdata
   );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: one memory port shared by IF fetch and MA access, MA priority with an IF starvation
// guard, one transaction in flight. Define MEMARB_TIMEOUT_EN to compile in the watchdog abort.
module mem_arb #(
   parameter int unsigned ADDR_W     = 24,
   parameter int unsigned DATA_W     = 24,
   parameter int unsigned STARVE_MAX = 3,
   parameter int unsigned TIMEOUT    = 64
) (
   input logic      iw_clk,
   input logic      iw_rst_n,
   mem_arb_if.slave bus
);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_RDWAIT = 2'd2;
   localparam int unsigned SW = $clog2(STARVE_MAX + 1);

   if (STARVE_MAX < 1 || TIMEOUT < 1) begin : g_bad_param
      $error("mem_arb: STARVE_MAX and TIMEOUT must both be >= 1");
   end

   logic [1:0]        state_q, state_d;
   logic              owner_q, owner_d;  // 1 = MA owns the transaction
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              if_gnt_q, if_gnt_d, ma_gnt_q, ma_gnt_d;
   logic              if_done_q, if_done_d, ma_done_q, ma_done_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d, ma_rdata_q, ma_rdata_d;
   logic              fin, if_wins;
   logic [DATA_W-1:0] fin_rdata;
`ifdef MEMARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              if_err_q, if_err_d, ma_err_q, ma_err_d;
   logic              fin_err;
`endif

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      starve_d   = starve_q;
      if_gnt_d   = 1'b0;
      ma_gnt_d   = 1'b0;
      if_done_d  = 1'b0;
      ma_done_d  = 1'b0;
      if_rdata_d = if_rdata_q;
      ma_rdata_d = ma_rdata_q;
      fin        = 1'b0;
      fin_rdata  = '0;
      if_wins    = 1'b0;
`ifdef MEMARB_TIMEOUT_EN
      cnt_d      = cnt_q + 1'b1;
      if_err_d   = 1'b0;
      ma_err_d   = 1'b0;
      fin_err    = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
`ifdef MEMARB_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (bus.iw_if_req || bus.iw_ma_req) begin
               // IF overrides MA only after STARVE_MAX consecutive contended losses
               if_wins = bus.iw_if_req && (!bus.iw_ma_req || starve_q == SW'(STARVE_MAX));
               owner_d = !if_wins;
               state_d = ST_ISSUE;
               if (if_wins) begin
                  we_d     = 1'b0;
                  addr_d   = bus.iw_if_addr;
                  wdata_d  = '0;
                  starve_d = '0;
                  if_gnt_d = 1'b1;
               end else begin
                  we_d     = bus.iw_ma_we;
                  addr_d   = bus.iw_ma_addr;
                  wdata_d  = bus.iw_ma_wdata;
                  ma_gnt_d = 1'b1;
                  if (bus.iw_if_req && starve_q != SW'(STARVE_MAX)) begin
                     starve_d = starve_q + 1'b1;
                  end
               end
            end
         end
         ST_ISSUE: begin
            if (bus.iw_mem_ack) begin
               if (we_q) begin
                  fin     = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_RDWAIT;
               end
            end
`ifdef MEMARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
               fin     = 1'b1;
               fin_err = 1'b1;
               state_d = ST_IDLE;
            end
`endif
         end
         ST_RDWAIT: begin
            if (bus.iw_mem_rvalid) begin
               fin       = 1'b1;
               fin_rdata = bus.iw_mem_rdata;
               state_d   = ST_IDLE;
            end
`ifdef MEMARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
               fin     = 1'b1;
               fin_err = 1'b1;
               state_d = ST_IDLE;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      if (fin) begin
         if (owner_q) begin
            ma_done_d  = 1'b1;
            ma_rdata_d = fin_rdata;
`ifdef MEMARB_TIMEOUT_EN
            ma_err_d   = fin_err;
`endif
         end else begin
            if_done_d  = 1'b1;
            if_rdata_d = fin_rdata;
`ifdef MEMARB_TIMEOUT_EN
            if_err_d   = fin_err;
`endif
         end
      end
   end

   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         starve_q   <= '0;
         if_gnt_q   <= 1'b0;
         ma_gnt_q   <= 1'b0;
         if_done_q  <= 1'b0;
         ma_done_q  <= 1'b0;
         if_rdata_q <= '0;
         ma_rdata_q <= '0;
`ifdef MEMARB_TIMEOUT_EN
         cnt_q      <= '0;
         if_err_q   <= 1'b0;
         ma_err_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         starve_q   <= starve_d;
         if_gnt_q   <= if_gnt_d;
         ma_gnt_q   <= ma_gnt_d;
         if_done_q  <= if_done_d;
         ma_done_q  <= ma_done_d;
         if_rdata_q <= if_rdata_d;
         ma_rdata_q <= ma_rdata_d;
`ifdef MEMARB_TIMEOUT_EN
         cnt_q      <= cnt_d;
         if_err_q   <= if_err_d;
         ma_err_q   <= ma_err_d;
`endif
      end
   end

   assign bus.or_mem_req   = (state_q == ST_ISSUE);
   assign bus.or_mem_we    = we_q;
   assign bus.or_mem_addr  = addr_q;
   assign bus.or_mem_wdata = wdata_q;
   assign bus.or_if_gnt    = if_gnt_q;
   assign bus.or_ma_gnt    = ma_gnt_q;
   assign bus.or_if_done   = if_done_q;
   assign bus.or_ma_done   = ma_done_q;
   assign bus.or_if_rdata  = if_rdata_q;
   assign bus.or_ma_rdata  = ma_rdata_q;
`ifdef MEMARB_TIMEOUT_EN
   assign bus.or_if_err    = if_err_q;
   assign bus.or_ma_err    = ma_err_q;
`else
   assign bus.or_if_err    = 1'b0;
   assign bus.or_ma_err    = 1'b0;
`endif
endmodule
